// File: rtl/wr_ingress_ctrl.sv
// -----------------------------------------------------------------------------
// wr_ingress_ctrl
//
// Write-side ingress stage of the async FIFO, in the w_clk domain. It takes a
// valid/ready stream from the producer, holds it in a 2-entry skid buffer and
// presents it to the FIFO write port. It also reports a conservative fill
// level and an almost_full flag, computed from the Gray write pointer and the
// synchronised Gray read pointer.
//
// Ports:
//   w_clk        in   write-domain clock
//   rst_n        in   asynchronous active-low reset
//   s_valid      in   producer word valid
//   s_data       in   producer word [WIDTH]
//   s_ready      out  ingress can accept a word (registered)
//   wfull        in   registered full flag from the write-pointer block
//   wptr         in   Gray write pointer [AW+1]
//   wsync_ptr2   in   Gray read pointer, synchronised into w_clk [AW+1]
//   wr_rq        out  write request to the FIFO write port
//   wdata        out  write data, valid while wr_rq=1 [WIDTH]
//   wlevel       out  registered fill level, 0..DEPTH [AW+1]
//   almost_full  out  registered flag, wlevel >= DEPTH - AF_MARGIN
//   stat_words   out  (WR_INGRESS_STATS_EN only) saturating count of writes
//   stat_stalls  out  (WR_INGRESS_STATS_EN only) saturating count of stalls
//
// Build option: define WR_INGRESS_STATS_EN to add the two statistics counters.
// -----------------------------------------------------------------------------
module wr_ingress_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             w_clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    input  logic             wfull,
    input  logic [AW:0]      wptr,
    input  logic [AW:0]      wsync_ptr2,
    output logic             wr_rq,
    output logic [WIDTH-1:0] wdata,
    output logic [AW:0]      wlevel,
    output logic             almost_full
`ifdef WR_INGRESS_STATS_EN
    ,
    output logic [15:0]      stat_words,
    output logic [15:0]      stat_stalls
`endif
);

    localparam int AW1 = AW + 1;
    localparam logic [AW:0] LVL_MAX   = AW1'(DEPTH);
    localparam logic [AW:0] AF_THRESH = AW1'(DEPTH - AF_MARGIN);

    // Skid buffer states, encoded as {o_valid, k_valid}.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_TWO   = 2'b11;

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // A pointer difference above DEPTH can only come from an illegal pointer
    // pair; clamp it so the level stays within 0..DEPTH.
    function automatic logic [AW:0] sat_level(input logic [AW:0] diff);
        return (diff > LVL_MAX) ? LVL_MAX : diff;
    endfunction

    logic             o_valid_q, o_valid_d;
    logic             k_valid_q, k_valid_d;
    logic [WIDTH-1:0] o_data_q,  o_data_d;
    logic [WIDTH-1:0] k_data_q,  k_data_d;
    logic             s_ready_q, s_ready_d;
    logic [AW:0]      wlevel_q,  wlevel_d;
    logic             almost_full_q, almost_full_d;

    logic accept;
    logic drain;

    assign accept = s_valid & s_ready_q;
    assign drain  = o_valid_q & ~wfull;

    // Output stage o is the head of the queue; k is the skid entry behind it.
    always_comb begin
        o_valid_d = o_valid_q;
        k_valid_d = k_valid_q;
        o_data_d  = o_data_q;
        k_data_d  = k_data_q;
        case ({o_valid_q, k_valid_q})
            ST_EMPTY: begin
                if (accept) begin
                    o_valid_d = 1'b1;
                    o_data_d  = s_data;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    o_data_d = s_data;
                end else if (accept) begin
                    k_valid_d = 1'b1;
                    k_data_d  = s_data;
                end else if (drain) begin
                    o_valid_d = 1'b0;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    o_data_d  = k_data_q;
                    k_valid_d = 1'b0;
                end
            end
            default: begin
                // Unreachable {0,1}: discard and fall back to empty.
                o_valid_d = 1'b0;
                k_valid_d = 1'b0;
            end
        endcase
        s_ready_d = ~k_valid_d;
    end

    always_comb begin
        wlevel_d      = sat_level(gray2bin(wptr) - gray2bin(wsync_ptr2));
        almost_full_d = (wlevel_d >= AF_THRESH);
    end

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_q     <= 1'b0;
            k_valid_q     <= 1'b0;
            o_data_q      <= '0;
            k_data_q      <= '0;
            s_ready_q     <= 1'b0;
            wlevel_q      <= '0;
            almost_full_q <= 1'b0;
        end else begin
            o_valid_q     <= o_valid_d;
            k_valid_q     <= k_valid_d;
            o_data_q      <= o_data_d;
            k_data_q      <= k_data_d;
            s_ready_q     <= s_ready_d;
            wlevel_q      <= wlevel_d;
            almost_full_q <= almost_full_d;
        end
    end

    // wr_rq follows the live wfull so the write-pointer block and this stage
    // agree on the same edge; it also drops with rst_n through o_valid_q.
    assign wr_rq       = drain;
    assign wdata       = o_data_q;
    assign s_ready     = s_ready_q;
    assign wlevel      = wlevel_q;
    assign almost_full = almost_full_q;

`ifdef WR_INGRESS_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    logic [15:0] stat_words_q,  stat_words_d;
    logic [15:0] stat_stalls_q, stat_stalls_d;

    always_comb begin
        stat_words_d  = sat_inc(stat_words_q, drain);
        stat_stalls_d = sat_inc(stat_stalls_q, s_valid & ~s_ready_q);
    end

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_words_q  <= stat_words_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_words  = stat_words_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
module tb_wr_ingress_ctrl;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int AF_MARGIN = 2;
    localparam int AW        = 4;

    logic             w_clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic             wfull;
    logic [AW:0]      wptr;
    logic [AW:0]      wsync_ptr2;
    logic             wr_rq;
    logic [WIDTH-1:0] wdata;
    logic [AW:0]      wlevel;
    logic             almost_full;
`ifdef WR_INGRESS_STATS_EN
    logic [15:0]      stat_words;
    logic [15:0]      stat_stalls;
`endif

    int total = 0;
    int bad   = 0;

    wr_ingress_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
        .w_clk       (w_clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .wfull       (wfull),
        .wptr        (wptr),
        .wsync_ptr2  (wsync_ptr2),
        .wr_rq       (wr_rq),
        .wdata       (wdata),
        .wlevel      (wlevel),
        .almost_full (almost_full)
`ifdef WR_INGRESS_STATS_EN
        ,
        .stat_words  (stat_words),
        .stat_stalls (stat_stalls)
`endif
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        logic [AW:0] wp;
        logic [AW:0] rp;
        int          lvl;
        logic        af;
    } lvl_vec_t;

    lvl_vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reference level: modulo pointer difference, clamped to DEPTH.
    function automatic int ref_level(input int wb, input int rb);
        int d;
        d = (wb - rb) & ((1 << (AW + 1)) - 1);
        return (d > DEPTH) ? DEPTH : d;
    endfunction

    byte unsigned q[$];

    initial begin
        int pw, pr, lv;
        bit exp_rdy, exp_wr;

        tbl[0] = '{5'h09, 5'h00, 14, 1'b1};
        tbl[1] = '{5'h09, 5'h03, 12, 1'b0};
        tbl[2] = '{5'h03, 5'h12,  6, 1'b0};
        tbl[3] = '{5'h00, 5'h00,  0, 1'b0};
        tbl[4] = '{5'h0B, 5'h00, 13, 1'b0};
        tbl[5] = '{5'h08, 5'h00, 15, 1'b1};
        tbl[6] = '{5'h18, 5'h00, 16, 1'b1};
        tbl[7] = '{5'h1E, 5'h00, 16, 1'b1};
        tbl[8] = '{5'h00, 5'h1E, 12, 1'b0};
        tbl[9] = '{5'h00, 5'h18, 16, 1'b1};

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; wfull = 1'b0;
        wptr = '0; wsync_ptr2 = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset in the middle of activity.
        wptr = 5'h09; wfull = 1'b1; s_valid = 1'b1; s_data = 8'h55;
        tick(); tick(); tick();
        wfull = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_wr_rq", wr_rq, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_wlevel", wlevel, 0);
        chk("rst_af", almost_full, 0);
        s_valid = 1'b0; wptr = '0;
        tick(); tick();
        chk("rst_hold_wr_rq", wr_rq, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_s_ready_lo", s_ready, 0);
        tick();
        chk("rel_s_ready_hi", s_ready, 1);
        chk("rel_wlevel", wlevel, 0);
        chk("rel_wr_rq", wr_rq, 0);

        // Back-to-back stream with wfull low.
        s_valid = 1'b1; s_data = 8'hA1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("b2b_wr_rq", wr_rq, 1);
            chk("b2b_wdata", wdata, 8'hA1 + i);
            chk("b2b_s_ready", s_ready, 1);
            if (i < 3) s_data = 8'hA2 + 8'(i);
            else s_valid = 1'b0;
            tick();
        end
        chk("b2b_idle", wr_rq, 0);
`ifdef WR_INGRESS_STATS_EN
        chk("stat_words4", stat_words, 4);
`endif

        // Stall with wfull high, then release.
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'hB1;
        tick();
        chk("full_rdy1", s_ready, 1);
        chk("full_wr1", wr_rq, 0);
        s_data = 8'hB2;
        tick();
        chk("full_rdy2", s_ready, 0);
        chk("full_wr2", wr_rq, 0);
        s_data = 8'hB3;
        tick();
        chk("full_rdy3", s_ready, 0);
        wfull = 1'b0;
        #1;
        chk("rel_wr_b1", wr_rq, 1);
        chk("rel_wd_b1", wdata, 8'hB1);
        tick();
        chk("rel_wd_b2", wdata, 8'hB2);
        chk("rel_wr_b2", wr_rq, 1);
        chk("rel_rdy", s_ready, 1);
        tick();
        s_valid = 1'b0;
        chk("rel_wd_b3", wdata, 8'hB3);
        chk("rel_wr_b3", wr_rq, 1);
        tick();
        chk("rel_empty", wr_rq, 0);

        // Level vectors.
        for (int i = 0; i < 10; i++) begin
            wptr = tbl[i].wp; wsync_ptr2 = tbl[i].rp;
            tick();
            chk($sformatf("lvl%0d", i), wlevel, tbl[i].lvl);
            chk($sformatf("af%0d", i), almost_full, tbl[i].af);
        end

        // Randomised stream and level against a queue model.
        wptr = '0; wsync_ptr2 = '0;
        tick();
        pw = 0; pr = 0;
        for (int n = 0; n < 400; n++) begin
            int wb, rb;
            s_valid = ($urandom_range(0, 9) < 7);
            s_data  = 8'($urandom);
            wfull   = ($urandom_range(0, 9) < 3);
            wb = $urandom_range(0, 31);
            rb = (wb - $urandom_range(0, 20)) & 31;
            wptr = bin2gray(5'(wb)); wsync_ptr2 = bin2gray(5'(rb));
            #2;
            exp_rdy = (q.size() < 2);
            exp_wr  = (q.size() > 0) && !wfull;
            chk("rnd_s_ready", s_ready, exp_rdy);
            chk("rnd_wr_rq", wr_rq, exp_wr);
            if (exp_wr) chk("rnd_wdata", wdata, q[0]);
            lv = ref_level(pw, pr);
            chk("rnd_wlevel", wlevel, lv);
            chk("rnd_af", almost_full, (lv >= DEPTH - AF_MARGIN));
            if (exp_wr) void'(q.pop_front());
            if (s_valid && exp_rdy) q.push_back(s_data);
            pw = wb; pr = rb;
            @(posedge w_clk);
            #1;
        end
        s_valid = 1'b0; wfull = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #2;
            chk("drain_wr_rq", wr_rq, (q.size() > 0));
            if (q.size() > 0) begin
                chk("drain_wdata", wdata, q[0]);
                void'(q.pop_front());
            end
            @(posedge w_clk);
            #1;
        end
        chk("drain_done", wr_rq, 0);

        // Fill to two entries, stall, then reset discards them.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'hC1;
        tick();
        s_data = 8'hC2;
        tick();
        chk("two_rdy", s_ready, 0);
        tick(); tick(); tick();
`ifdef WR_INGRESS_STATS_EN
        chk("stat_stalls3", stat_stalls, 3);
`endif
        wfull = 1'b0;
        #1;
        chk("pre_rst_wr", wr_rq, 1);
        rst_n = 1'b0;
        #1;
        chk("async_wr_drop", wr_rq, 0);
`ifdef WR_INGRESS_STATS_EN
        chk("stat_stalls_rst", stat_stalls, 0);
`endif
        s_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("no_stale_wr", wr_rq, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
